device_register_bank: RTL and testbench

- Parametrised successor to the CPU-side device register file. Maps 2^ADDR_WIDTH registers onto the CPU data bus, with shared `data_out` tristated when not reading.
- New relative to the plain register file:
  - a device-side write path for registers the device owns;
  - per-register CPU write strobes;
  - per-register "new data from device" flags with an interrupt output.
- Sits between the CPU bus and peripheral blocks (timers, I/O latches, UART-style devices).

---
 rtl/device_register_bank.sv | 118 +++++++++++
 tb/tb_device_register_bank.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/device_register_bank.sv
// CPU/device shared register bank: CPU reads and writes over a tristate bus, a device write path
// for device-owned registers, and "new data" flags with an interrupt (built only with DEVICE_IRQ_EN).
module device_register_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter logic [(1 << ADDR_WIDTH)-1:0] DEV_OWNED_MASK = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           address,
  input  logic                            enable,
  input  logic                            mode,
  input  logic [DATA_WIDTH-1:0]           data_in,
  output logic [DATA_WIDTH-1:0]           data_out,
  input  logic [(1 << ADDR_WIDTH)-1:0]    dev_wr_en,
  input  logic [DATA_WIDTH-1:0]           dev_wr_data [1 << ADDR_WIDTH],
  output logic [DATA_WIDTH-1:0]           device_data [1 << ADDR_WIDTH],
  output logic [(1 << ADDR_WIDTH)-1:0]    cpu_wr_strobe,
  output logic [(1 << ADDR_WIDTH)-1:0]    dev_new,
  output logic                            irq
);

  localparam int N = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [N];
  logic [DATA_WIDTH-1:0] regs_d [N];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] rd_d;
  logic [N-1:0]          strobe_q;
  logic [N-1:0]          strobe_d;
  logic                  cpu_rd_s;
  logic                  cpu_wr_s;

  assign cpu_rd_s = enable && mode;
  assign cpu_wr_s = enable && !mode && !DEV_OWNED_MASK[address];

  // Next-state for the register array, read latch and CPU write strobes
  always_comb begin
    regs_d   = regs_q;
    rd_d     = rd_q;
    strobe_d = '0;
    if (cpu_rd_s) begin
      rd_d = regs_q[address];
    end else begin
      rd_d = rd_q;
    end
    if (cpu_wr_s) begin
      regs_d[address]   = data_in;
      strobe_d[address] = 1'b1;
    end else begin
      strobe_d = '0;
    end
    // Ownership is exclusive, so device writes never land on a CPU-written register.
    for (int i = 0; i < N; i++) begin
      if (dev_wr_en[i] && DEV_OWNED_MASK[i]) begin
        regs_d[i] = dev_wr_data[i];
      end else begin
        regs_d[i] = regs_d[i];
      end
    end
  end

  // Falling-edge state update with synchronous reset taking priority over every access
  always_ff @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
      rd_q     <= {DATA_WIDTH{1'b0}};
      strobe_q <= '0;
    end else begin
      regs_q   <= regs_d;
      rd_q     <= rd_d;
      strobe_q <= strobe_d;
    end
  end

`ifdef DEVICE_IRQ_EN
  logic [N-1:0] new_q;
  logic [N-1:0] new_d;
  logic         irq_q;
  logic         irq_d;

  // A device write on the same edge as the CPU read of that register keeps the flag set
  always_comb begin
    new_d = new_q;
    if (cpu_rd_s) begin
      new_d[address] = 1'b0;
    end else begin
      new_d = new_q;
    end
    new_d = (new_d | dev_wr_en) & DEV_OWNED_MASK;
    irq_d = |new_d;
  end

  // Flag and interrupt registers
  always_ff @(negedge clk) begin
    if (reset) begin
      new_q <= '0;
      irq_q <= 1'b0;
    end else begin
      new_q <= new_d;
      irq_q <= irq_d;
    end
  end

  assign dev_new = new_q;
  assign irq     = irq_q;
`else
  assign dev_new = '0;
  assign irq     = 1'b0;
`endif

  assign device_data   = regs_q;
  assign cpu_wr_strobe = strobe_q;
  assign data_out      = cpu_rd_s ? rd_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_device_register_bank.sv
// Scoreboard bench for device_register_bank: stimulus queues expected values tagged with the
// falling-edge count they belong to; a monitor pops and compares them on the following rising edge.
module tb_device_register_bank;

  localparam int N = 16;
`ifdef DEVICE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [15:0] NEW15 = IRQ_EN ? 16'h8000 : 16'h0000;
  localparam logic [15:0] IRQ1  = IRQ_EN ? 16'h0001 : 16'h0000;

  localparam int K_DD  = 0;
  localparam int K_STB = 1;
  localparam int K_NEW = 2;
  localparam int K_IRQ = 3;
  localparam int K_OUT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] address;
  logic       enable;
  logic       mode;
  logic [7:0] data_in;
  wire  [7:0] data_out;
  logic [15:0] dev_wr_en;
  logic [7:0] dev_wr_data [N];
  logic [7:0] device_data [N];
  logic [15:0] cpu_wr_strobe;
  logic [15:0] dev_new;
  logic       irq;

  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // An undriven bus reads as 8'hFF through the pull-ups.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data_out[g]);
  end

  device_register_bank #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .DEV_OWNED_MASK(16'h8000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .enable(enable),
    .mode(mode),
    .data_in(data_in),
    .data_out(data_out),
    .dev_wr_en(dev_wr_en),
    .dev_wr_data(dev_wr_data),
    .device_data(device_data),
    .cpu_wr_strobe(cpu_wr_strobe),
    .dev_new(dev_new),
    .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] sample(int kind, int idx);
    case (kind)
      K_DD:    return {8'h00, device_data[idx]};
      K_STB:   return cpu_wr_strobe;
      K_NEW:   return dev_new;
      K_IRQ:   return {15'h0000, irq};
      default: return {8'h00, data_out};
    endcase
  endfunction

  // Monitor: compares every queued expectation due at this rising edge
  initial begin
    exp_t e;
    logic [15:0] got;
    forever begin
      @(posedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        got = sample(e.kind, e.idx);
        checks++;
        if (e.cyc < cyc) begin
          failures++;
          $display("FAIL %s: check missed its edge (due %0d, now %0d)", e.name, e.cyc, cyc);
        end else if (got !== e.exp) begin
          failures++;
          $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
      end
    end
  end

  task automatic expect_after(int kind, int idx, logic [15:0] exp, string name);
    exp_t e;
    e.cyc  = cyc + 1;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic drive(bit rst, bit en, bit md, int addr, logic [7:0] din,
                       logic [15:0] dwe, logic [7:0] d15);
    @(posedge clk);
    #1;
    reset           = rst;
    enable          = en;
    mode            = md;
    address         = addr[3:0];
    data_in         = din;
    dev_wr_en       = dwe;
    dev_wr_data[15] = d15;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    mode      = 1'b0;
    address   = 4'h0;
    data_in   = 8'h00;
    dev_wr_en = 16'h0000;
    for (int i = 0; i < N; i++) dev_wr_data[i] = 8'h00;
    dev_wr_data[3] = 8'h99;

    drive(1'b1, 1'b0, 1'b0, 0, 8'h00, 16'h0000, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 0, 8'h00, 16'h0000, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 0, 8'h00, 16'h0000, 8'h00);
    expect_after(K_DD, 3, 16'h0000, "rst_dd3");
    expect_after(K_DD, 15, 16'h0000, "rst_dd15");
    expect_after(K_STB, 0, 16'h0000, "rst_strobe");
    expect_after(K_NEW, 0, 16'h0000, "rst_dev_new");
    expect_after(K_IRQ, 0, 16'h0000, "rst_irq");
    expect_after(K_OUT, 0, 16'h00FF, "rst_bus_z");

    drive(1'b0, 1'b1, 1'b0, 3, 8'hA5, 16'h0000, 8'h00);
    expect_after(K_DD, 3, 16'h00A5, "wr3_dd");
    expect_after(K_STB, 0, 16'h0008, "wr3_strobe");
    drive(1'b0, 1'b0, 1'b0, 0, 8'h00, 16'h0000, 8'h00);
    expect_after(K_STB, 0, 16'h0000, "wr3_strobe_clear");
    expect_after(K_DD, 3, 16'h00A5, "wr3_hold");
    drive(1'b0, 1'b1, 1'b1, 3, 8'h00, 16'h0000, 8'h00);
    expect_after(K_OUT, 0, 16'h00A5, "rd3_data");
    drive(1'b0, 1'b0, 1'b0, 0, 8'h00, 16'h0000, 8'h00);
    expect_after(K_OUT, 0, 16'h00FF, "idle_bus_z");

    drive(1'b0, 1'b1, 1'b0, 15, 8'h55, 16'h0000, 8'h00);
    expect_after(K_DD, 15, 16'h0000, "wr15_ignored");
    expect_after(K_STB, 0, 16'h0000, "wr15_no_strobe");

    drive(1'b0, 1'b0, 1'b0, 0, 8'h00, 16'h8008, 8'h3C);
    expect_after(K_DD, 15, 16'h003C, "dev15_dd");
    expect_after(K_DD, 3, 16'h00A5, "dev3_unowned");
    expect_after(K_NEW, 0, NEW15, "dev15_new");
    expect_after(K_IRQ, 0, IRQ1, "dev15_irq");
    drive(1'b0, 1'b1, 1'b1, 15, 8'h00, 16'h0000, 8'h00);
    expect_after(K_OUT, 0, 16'h003C, "rd15_data");
    expect_after(K_NEW, 0, 16'h0000, "rd15_new_clr");
    expect_after(K_IRQ, 0, 16'h0000, "rd15_irq_clr");

    drive(1'b0, 1'b0, 1'b0, 0, 8'h00, 16'h8000, 8'h3C);
    expect_after(K_NEW, 0, NEW15, "dev15_new_again");
    drive(1'b0, 1'b1, 1'b1, 15, 8'h00, 16'h8000, 8'h7E);
    expect_after(K_OUT, 0, 16'h003C, "rdwr_old_data");
    expect_after(K_DD, 15, 16'h007E, "rdwr_dd");
    expect_after(K_NEW, 0, NEW15, "rdwr_new_kept");
    expect_after(K_IRQ, 0, IRQ1, "rdwr_irq_kept");
    drive(1'b0, 1'b1, 1'b1, 15, 8'h00, 16'h0000, 8'h00);
    expect_after(K_OUT, 0, 16'h007E, "rd15_new_data");
    expect_after(K_NEW, 0, 16'h0000, "rd15_new_clr2");

    drive(1'b0, 1'b1, 1'b0, 2, 8'h44, 16'h0000, 8'h00);
    expect_after(K_DD, 2, 16'h0044, "wr2_dd");
    expect_after(K_STB, 0, 16'h0004, "wr2_strobe");
    drive(1'b1, 1'b1, 1'b0, 2, 8'hFF, 16'h0000, 8'h00);
    expect_after(K_DD, 2, 16'h0000, "rstwr_dd2");
    expect_after(K_DD, 15, 16'h0000, "rstwr_dd15");
    expect_after(K_STB, 0, 16'h0000, "rstwr_no_strobe");
    expect_after(K_OUT, 0, 16'h00FF, "rstwr_bus_z");

    drive(1'b0, 1'b1, 1'b0, 2, 8'h11, 16'h0000, 8'h00);
    expect_after(K_STB, 0, 16'h0004, "wr2b_strobe");
    drive(1'b0, 1'b1, 1'b0, 5, 8'h22, 16'h0000, 8'h00);
    expect_after(K_STB, 0, 16'h0020, "wr5_strobe");
    expect_after(K_DD, 5, 16'h0022, "wr5_dd");
    drive(1'b0, 1'b1, 1'b1, 2, 8'h00, 16'h0000, 8'h00);
    expect_after(K_OUT, 0, 16'h0011, "b2b_rd2");
    expect_after(K_STB, 0, 16'h0000, "rd_no_strobe");
    drive(1'b0, 1'b1, 1'b1, 5, 8'h00, 16'h0000, 8'h00);
    expect_after(K_OUT, 0, 16'h0022, "b2b_rd5");
    drive(1'b1, 1'b1, 1'b1, 5, 8'h00, 16'h0000, 8'h00);
    expect_after(K_OUT, 0, 16'h0000, "rst_rd_latch");
    drive(1'b0, 1'b0, 1'b0, 0, 8'h00, 16'h0000, 8'h00);
    expect_after(K_OUT, 0, 16'h00FF, "final_bus_z");

    repeat (3) @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: never compared (due %0d)", e.name, e.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
